// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

    localparam int unsigned DEF_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOTB = 4'b0101,
        OP_SHL  = 4'b0110,
        OP_SHR  = 4'b0111,
        OP_CLR  = 4'b1000,
        OP_PASA = 4'b1001,
        OP_PASB = 4'b1010,
        OP_PARB = 4'b1011,
        OP_MUL  = 4'b1100,
        OP_ROL  = 4'b1101,
        OP_ROR  = 4'b1110,
        OP_ASR  = 4'b1111
    } op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath; produces 0 for MUL, which is handled iteratively by alu_seq.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned SHW = $clog2(W)
) (
    input  op_t          i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sc,
    output logic [W-1:0] o_y,
    output logic         o_sc
);

    logic [W:0]  w_add;
    logic [W:0]  w_sub;
    logic [31:0] w_amt;

    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_sc};
    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
    // Rotate amount reduced modulo W so non-power-of-two widths still wrap correctly
    assign w_amt = 32'(i_b[SHW-1:0]) % 32'(W);

    always_comb begin
        o_y  = '0;
        o_sc = 1'b0;
        case (i_op)
            OP_ADD:  {o_sc, o_y} = w_add;
            OP_SUB:  {o_sc, o_y} = w_sub;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NOTB: o_y = ~i_b;
            OP_SHL:  o_y = i_a << i_b;
            OP_SHR:  o_y = i_a >> i_b;
            OP_CLR:  o_y = '0;
            OP_PASA: {o_sc, o_y} = {i_sc, i_a};
            OP_PASB: {o_sc, o_y} = {i_sc, i_b};
            OP_PARB: o_y = {{(W-1){1'b0}}, ^i_b};
            OP_MUL:  o_y = '0;
            OP_ROL:  o_y = (i_a << w_amt) | (i_a >> (32'(W) - w_amt));
            OP_ROR:  o_y = (i_a >> w_amt) | (i_a << (32'(W) - w_amt));
            OP_ASR:  o_y = $unsigned($signed(i_a) >>> i_b);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_core, unsigned MUL via a W-step shift-add loop.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned SHW = $clog2(W)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sc,
    output logic [W-1:0] o_out,
    output logic [W-1:0] o_hi,
    output logic         o_sc,
    output logic         o_zero,
    output logic         o_parity,
    output logic         o_odd,
    output logic         o_negative,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_prod;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_out;
    logic [W-1:0]   r_hi;
    logic           r_sc;
    logic           r_busy;
    logic           r_done;

    op_t            w_op;
    logic [W-1:0]   w_y;
    logic           w_sc;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_prod_next;

    assign w_op = op_t'(i_op);

    alu_core #(
        .W   (W),
        .SHW (SHW)
    ) u_core (
        .i_op (w_op),
        .i_a  (i_a),
        .i_b  (i_b),
        .i_sc (i_sc),
        .o_y  (w_y),
        .o_sc (w_sc)
    );

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out bit by bit
    assign w_sum       = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_sum, r_prod[W-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_out   <= '0;
            r_hi    <= '0;
            r_sc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_op == OP_MUL) begin
                            r_prod  <= {{W{1'b0}}, i_b};
                            r_mcand <= i_a;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= MUL;
                        end else begin
                            r_out  <= w_y;
                            r_hi   <= '0;
                            r_sc   <= w_sc;
                            r_done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (r_cnt == CNT_LAST) begin
                        r_out   <= w_prod_next[W-1:0];
                        r_hi    <= w_prod_next[2*W-1:W];
                        r_sc    <= |w_prod_next[2*W-1:W];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_prod <= w_prod_next;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out      = r_out;
    assign o_hi       = r_hi;
    assign o_sc       = r_sc;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_zero     = ~|r_out;
    assign o_parity   = ^r_out;
    assign o_odd      = r_out[0];
    assign o_negative = r_out[W-1];

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 8: datapath width in bits, legal for W >= 4.
REQ-002 Parameter SHW, default $clog2(W): number of shift-amount bits used by the rotate operations.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Start  input  1  request strobe; sampled at a rising edge while Busy=0.
REQ-006 OP  input  4  opcode, sampled with Start.
REQ-007 InputA, InputB  input  W each  operands, sampled with Start.
REQ-008 SC_in  input  1  carry/shift-in bit, sampled with Start.
REQ-009 Out  output  W  registered result, low W bits for MUL.
REQ-010 Hi  output  W  registered high half of the MUL product, 0 for all other ops.
REQ-011 SC_out  output  1  registered carry/borrow out; for MUL, set when Hi != 0.
REQ-012 Zero, Parity, Odd, Negative  output  1 each  derived from registered Out: ~|Out, ^Out, Out[0], Out[W-1].
REQ-013 Busy  output  1  high while a multi-cycle op is in progress.
REQ-014 Done  output  1  one-cycle pulse marking Out/Hi/SC_out as newly valid.

Function
REQ-015 Single-cycle opcodes SHALL behave as follows:
- 0000: {SC_out,Out} = A+B+SC_in.
- 0001: {SC_out,Out} = A+~B+1.
- 0010: AND.
- 0011: OR.
- 0100: XOR.
- 0101: ~B.
- 0110: A<<B.
- 0111: A>>B.
- 1000: clear Out and SC_out.
- 1001: {SC_in,A}.
- 1010: {SC_in,B}.
- 1011: Out = zero-extended ^B.
REQ-016 New opcodes SHALL be:
- 1100: MUL, unsigned, {Hi,Out} = A*B.
- 1101: ROL by B[SHW-1:0].
- 1110: ROR by B[SHW-1:0].
- 1111: ASR, arithmetic right shift by B.
REQ-017 Shift width rules:
- Logical shifts and ASR SHALL use the full B value.
- Amount >= W yields 0 for a logical shift and W copies of A[W-1] for ASR.
- Rotates SHALL use the amount modulo W.
REQ-018 SC_out SHALL be 0 for opcodes 0010-0111 and 1011-1111, except for MUL (see REQ-011).
REQ-019 FSM states SHALL be IDLE and MUL; DONE is a flag, not a state.
REQ-020 Start with a single-cycle opcode, sampled at edge t: Out/Hi/SC_out update at edge t and Done=1 for the cycle after t; state stays IDLE.
REQ-021 Start with MUL at edge t: IDLE->MUL, Busy=1 after edge t, and operands are latched.
- One shift-add iteration per edge, W iterations total.
- At edge t+W: state returns to IDLE, Busy=0, results load, and Done=1 for one cycle.
REQ-022 Start while Busy=1 SHALL be ignored: no operand capture and no effect on the running op.
REQ-023 Start held high in IDLE SHALL start a new op every edge; back-to-back single-cycle ops give Done high on consecutive cycles.
REQ-024 Out, Hi, SC_out and flags SHALL hold their last values until the next op completes, including while Busy=1.
REQ-025 Done SHALL NOT assert without a preceding accepted Start.
REQ-026 Every 4-bit OP value is defined; no illegal-opcode state exists.

Reset
REQ-027 Reset_n=0 SHALL asynchronously force:
- state IDLE; Out=0, Hi=0, SC_out=0, Busy=0, Done=0;
- therefore Zero=1 and Parity/Odd/Negative=0.
REQ-028 Reset during MUL SHALL abort the op with no Done and no partial result visible.
REQ-029 The first Start SHALL be accepted at the first rising edge after Reset_n deasserts.

Structure
REQ-030 Shared package alu_pkg SHALL hold:
- op_t enum with the 16 opcodes;
- state_t enum {IDLE, MUL};
- the default width constant.
REQ-031 Sub-module alu_core SHALL hold the combinational single-cycle datapath (opcodes 0000-1011, 1101-1111) and be parametrised by W.
REQ-032 The multiplier SHALL be an iterative shift-add unit inside alu_seq; no combinational W x W multiplier.

Verification (W=8)
REQ-033 ADD A=0xF0 B=0x20 SC_in=1 -> Out=0x11, SC_out=1, Done one cycle after Start; SUB A=0x05 B=0x05 -> Out=0x00, Zero=1, SC_out=1.
REQ-034 MUL 0x0F*0x11 -> Out=0xFF, Hi=0x00, SC_out=0; MUL 0xFF*0xFF -> Out=0x01, Hi=0xFE, SC_out=1; Busy high 8 cycles, Done at edge t+8.
REQ-035 Shifts:
- ROR A=0x81 B=0x09 -> Out=0xC0;
- ROL A=0x81 B=0x01 -> Out=0x03;
- ASR A=0x80 B=0x03 -> Out=0xF0;
- ASR A=0x80 B=0x0A -> Out=0xFF;
- SHL A=0x01 B=0x08 -> Out=0x00, Zero=1.
REQ-036 Start XOR issued during MUL busy cycle 3 -> ignored; MUL result is unchanged and exactly one Done occurs.
REQ-037 Reset_n pulsed low during MUL cycle 4 -> Out=0, Hi=0, Busy=0, no Done; a following ADD 0x01+0x01 -> Out=0x02 with Done.
REQ-038 Start held high for 3 consecutive AND ops -> Done high 3 consecutive cycles with the matching results.
